// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: FSM state encoding and small helpers.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_SCAN = 2'd1;
   localparam logic [1:0] STATE_DONE = 2'd2;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load has priority so a reload on the terminal cycle restarts the dwell cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a decoder address from 0 up to a captured last address, holding each for dwell+1 cycles.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int DWELL_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [DWELL_WIDTH-1:0] dwell,
   input  logic [ADDR_WIDTH-1:0]  last_addr,
   output logic [ADDR_WIDTH-1:0]  address_out,
   output logic                   en_out,
   output logic                   busy,
   output logic                   done
);

   scan_state_t            state;
   scan_state_t            next_state;
   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic [ADDR_WIDTH-1:0]  addr_next;
   logic [DWELL_WIDTH-1:0] dwell_cap;
   logic [ADDR_WIDTH-1:0]  last_cap;
   logic                   capture;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic [DWELL_WIDTH-1:0] cnt_value;
   logic                   cnt_zero;

   down_counter #(
      .WIDTH(DWELL_WIDTH)
   ) u_dwell_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .dec       (cnt_dec),
      .load_value(cnt_value),
      .zero      (cnt_zero)
   );

   // Next-state, next-address and counter control; stop beats everything in SCAN.
   always_comb begin
      next_state = state;
      addr_next  = addr_reg;
      capture    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_value  = dwell_cap;
      case (state)
         IDLE: begin
            addr_next = '0;
            if (start && !stop) begin
               next_state = SCAN;
               capture    = 1'b1;
               cnt_load   = 1'b1;
               cnt_value  = dwell;
            end
         end
         SCAN: begin
            if (stop) begin
               next_state = IDLE;
               addr_next  = '0;
            end else if (cnt_zero) begin
               if (addr_reg == last_cap) begin
                  next_state = DONE;
                  addr_next  = '0;
               end else begin
                  addr_next = addr_reg + ADDR_WIDTH'(1);
                  cnt_load  = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
            addr_next  = '0;
         end
         default: begin
            next_state = IDLE;
            addr_next  = '0;
         end
      endcase
   end

   // The address is registered so the decoder never sees combinational glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_reg  <= '0;
         dwell_cap <= '0;
         last_cap  <= '0;
      end else begin
         state    <= next_state;
         addr_reg <= addr_next;
         if (capture) begin
            dwell_cap <= dwell;
            last_cap  <= last_addr;
         end
      end
   end

   assign address_out = addr_reg;
   assign en_out      = (state == SCAN);
   assign busy        = (state == SCAN);
   assign done        = (state == DONE);

endmodule
